// File: rtl/vec_unit_seq_if.sv
// Request/response bundle between the vector register file, the vector unit and writeback.
interface vec_unit_seq_if #(
    parameter int WIDTH = 128
);
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    shortreal   data_inK;
    shortreal   data_in1 [WIDTH];
    shortreal   data_in2 [WIDTH];
    logic       out_valid;
    logic       out_ready;
    shortreal   data_out [WIDTH];
    shortreal   data_outK;
    logic       op_err;

    modport master (
        output in_valid, op, data_inK, data_in1, data_in2, out_ready,
        input  in_ready, out_valid, data_out, data_outK, op_err
    );

    modport slave (
        input  in_valid, op, data_inK, data_in1, data_in2, out_ready,
        output in_ready, out_valid, data_out, data_outK, op_err
    );
endinterface

// File: rtl/vec_unit_seq.sv
// Multi-cycle vector unit: latches one operation, computes LANES elements per beat,
// and holds the vector/scalar result until writeback accepts it.
module vec_unit_seq #(
    parameter int WIDTH = 128,
    parameter int LANES = 16
) (
    input  logic          clock,
    input  logic          reset,
    vec_unit_seq_if.slave bus
);
    // state  | meaning
    // S_IDLE | ready for a request, operands are latched on in_valid
    // S_RUN  | one beat of LANES elements per cycle, reductions folded in
    // S_DONE | result held with out_valid until out_ready

    localparam int BEATS = WIDTH / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    localparam logic [3:0] OP_ADD     = 4'd1;
    localparam logic [3:0] OP_SUB     = 4'd2;
    localparam logic [3:0] OP_DOT     = 4'd3;
    localparam logic [3:0] OP_SCALE   = 4'd4;
    localparam logic [3:0] OP_DELTA   = 4'd5;
    localparam logic [3:0] OP_SIGMOID = 4'd6;
    localparam logic [3:0] OP_TANH    = 4'd7;
    localparam logic [3:0] OP_RELU    = 4'd8;
    localparam logic [3:0] OP_RSUM    = 4'd9;
    localparam logic [3:0] OP_RMAX    = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [BW-1:0]   beat;
    logic [3:0]      op_q;
    logic            err_q;
    shortreal        k_q;
    shortreal        a_q   [WIDTH];
    shortreal        b_q   [WIDTH];
    shortreal        res_q [WIDTH];
    shortreal        acc_q, acc_nxt;
    shortreal        lane_res [LANES];
    logic [IW-1:0]   lane_idx [LANES];

    function automatic shortreal elem(input logic [3:0] code, input shortreal a,
                                      input shortreal b, input shortreal k);
        shortreal r;
        case (code)
            OP_ADD:     r = a + b;
            OP_SUB:     r = a - b;
            OP_DOT:     r = a * b;
            OP_SCALE:   r = a * k;
            OP_DELTA:   r = a + k;
            OP_SIGMOID: r = 1.0 / (1.0 + $exp(-a));
            OP_TANH:    r = $tanh(a);
            OP_RELU:    r = (a >= 0.0) ? a : 0.0;
            default:    r = 0.0;
        endcase
        return r;
    endfunction

    // Reductions fold lanes in ascending index order; their vector lanes are written as 0.0.
    always_comb begin
        acc_nxt = acc_q;
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = IW'(int'(beat) * LANES + l);
            lane_res[l] = 0.0;
            if (op_q == OP_RSUM) begin
                acc_nxt = acc_nxt + a_q[lane_idx[l]] * b_q[lane_idx[l]];
            end else if (op_q == OP_RMAX) begin
                if (a_q[lane_idx[l]] > acc_nxt) acc_nxt = a_q[lane_idx[l]];
            end else begin
                lane_res[l] = elem(op_q, a_q[lane_idx[l]], b_q[lane_idx[l]], k_q);
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (beat == LAST_BEAT) state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            beat  <= '0;
            err_q <= 1'b0;
            acc_q <= 0.0;
            for (int i = 0; i < WIDTH; i++) res_q[i] <= 0.0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q  <= bus.op;
                        k_q   <= bus.data_inK;
                        beat  <= '0;
                        err_q <= (bus.op > OP_RMAX);
                        acc_q <= (bus.op == OP_RMAX) ? bus.data_in1[0] : 0.0;
                        for (int i = 0; i < WIDTH; i++) begin
                            a_q[i] <= bus.data_in1[i];
                            b_q[i] <= bus.data_in2[i];
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= acc_nxt;
                    for (int l = 0; l < LANES; l++) res_q[lane_idx[l]] <= lane_res[l];
                    if (beat != LAST_BEAT) beat <= beat + 1'b1;
                end
                S_DONE: begin
                    if (bus.out_ready) err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.data_out  = res_q;
    assign bus.data_outK = acc_q;
    assign bus.op_err    = err_q && (state == S_DONE);
endmodule

// File: tb/tb_vec_unit_seq.sv
// Directed bench for vec_unit_seq at LANES=16 plus back-to-back spacing at LANES=128 and LANES=1.
module tb_vec_unit_seq;
    logic       clock = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] op;
    shortreal   k;
    shortreal   a [128];
    shortreal   b [128];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int acc16[$];
    int acc128[$];
    int acc1[$];

    always #5 clock = ~clock;

    vec_unit_seq_if #(.WIDTH(128)) bus16 ();
    vec_unit_seq_if #(.WIDTH(128)) bus128 ();
    vec_unit_seq_if #(.WIDTH(128)) bus1 ();

    assign bus16.in_valid   = in_valid;
    assign bus16.op         = op;
    assign bus16.data_inK   = k;
    assign bus16.data_in1   = a;
    assign bus16.data_in2   = b;
    assign bus16.out_ready  = out_ready;
    assign bus128.in_valid  = in_valid;
    assign bus128.op        = op;
    assign bus128.data_inK  = k;
    assign bus128.data_in1  = a;
    assign bus128.data_in2  = b;
    assign bus128.out_ready = out_ready;
    assign bus1.in_valid    = in_valid;
    assign bus1.op          = op;
    assign bus1.data_inK    = k;
    assign bus1.data_in1    = a;
    assign bus1.data_in2    = b;
    assign bus1.out_ready   = out_ready;

    vec_unit_seq #(.WIDTH(128), .LANES(16))  u_dut16  (.clock(clock), .reset(reset), .bus(bus16));
    vec_unit_seq #(.WIDTH(128), .LANES(128)) u_dut128 (.clock(clock), .reset(reset), .bus(bus128));
    vec_unit_seq #(.WIDTH(128), .LANES(1))   u_dut1   (.clock(clock), .reset(reset), .bus(bus1));

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (bus16.in_valid && bus16.in_ready)   acc16.push_back(cyc);
            if (bus128.in_valid && bus128.in_ready) acc128.push_back(cyc);
            if (bus1.in_valid && bus1.in_ready)     acc1.push_back(cyc);
        end
    end

    task automatic check(input string tag, input real got, input real exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %g expected %g", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Issues one request from IDLE and returns the cycles from accept edge to out_valid.
    task automatic do_op(input logic [3:0] code, input shortreal kv, output int lat);
        op       = code;
        k        = kv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!bus16.out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic accept_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic int count_nonzero16();
        int n = 0;
        for (int i = 0; i < 128; i++) if (bus16.data_out[i] != 0.0) n++;
        return n;
    endfunction

    initial begin
        int lat;
        int bad;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'd0;
        k         = 0.0;
        for (int i = 0; i < 128; i++) begin
            a[i] = 0.0;
            b[i] = 0.0;
        end
        tick();
        tick();
        reset = 1'b0;
        check("rst_in_ready", bus16.in_ready, 1);
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_op_err", bus16.op_err, 0);
        check("rst_data_outK", bus16.data_outK, 0.0);
        check("rst_data_out_nonzero", count_nonzero16(), 0);

        // ADD
        for (int i = 0; i < 128; i++) begin
            a[i] = 1.0 * i;
            b[i] = 2.0 * i;
        end
        do_op(4'd1, 0.0, lat);
        check("add_latency", lat, 8);
        bad = 0;
        for (int i = 0; i < 128; i++) if (bus16.data_out[i] != 3.0 * i) bad++;
        check("add_data_bad", bad, 0);
        check("add_data_out_127", bus16.data_out[127], 381.0);
        check("add_data_outK", bus16.data_outK, 0.0);
        check("add_op_err", bus16.op_err, 0);
        accept_result();
        check("add_out_valid_drop", bus16.out_valid, 0);

        // Reset held mid-RUN at beat 3
        op       = 4'd2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrun_rst_in_ready", bus16.in_ready, 1);
        check("midrun_rst_out_valid", bus16.out_valid, 0);
        check("midrun_rst_data_nonzero", count_nonzero16(), 0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus16.out_valid) bad++;
            tick();
        end
        check("midrun_rst_stays_idle", bad, 0);

        // RSUM
        for (int i = 0; i < 128; i++) begin
            a[i] = 1.0;
            b[i] = 0.5;
        end
        do_op(4'd9, 0.0, lat);
        check("rsum_latency", lat, 8);
        check("rsum_data_outK", bus16.data_outK, 64.0);
        check("rsum_data_nonzero", count_nonzero16(), 0);
        accept_result();

        // RMAX, then back-pressure for 20 cycles with a competing request
        for (int i = 0; i < 128; i++) a[i] = 1.0 * (i - 64);
        do_op(4'd10, 0.0, lat);
        check("rmax_data_outK", bus16.data_outK, 63.0);
        check("rmax_data_nonzero", count_nonzero16(), 0);
        for (int i = 0; i < 128; i++) a[i] = 1000.0;
        op       = 4'd1;
        in_valid = 1'b1;
        bad      = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!bus16.out_valid || bus16.in_ready || bus16.data_outK != 63.0 ||
                bus16.data_out[0] != 0.0 || bus16.data_out[127] != 0.0) bad++;
        end
        check("backpressure_unstable_cycles", bad, 0);
        in_valid = 1'b0;
        accept_result();
        check("backpressure_out_valid_drop", bus16.out_valid, 0);
        check("backpressure_idle_in_ready", bus16.in_ready, 1);

        // RELU
        for (int i = 0; i < 128; i++) a[i] = (i % 2 == 1) ? -1.0 * i : 1.0 * i;
        a[0] = -1.0;
        a[1] = 0.0;
        a[2] = 2.5;
        do_op(4'd8, 0.0, lat);
        check("relu_d0", bus16.data_out[0], 0.0);
        check("relu_d1", bus16.data_out[1], 0.0);
        check("relu_d2", bus16.data_out[2], 2.5);
        bad = 0;
        for (int i = 3; i < 128; i++) if (bus16.data_out[i] != ((i % 2 == 1) ? 0.0 : 1.0 * i)) bad++;
        check("relu_rest_bad", bad, 0);
        accept_result();

        // SCALE and SUB
        for (int i = 0; i < 128; i++) begin
            a[i] = 1.0 * i;
            b[i] = 4.0;
        end
        do_op(4'd4, 0.5, lat);
        check("scale_d100", bus16.data_out[100], 50.0);
        check("scale_d7", bus16.data_out[7], 3.5);
        accept_result();
        do_op(4'd2, 0.0, lat);
        check("sub_d0", bus16.data_out[0], -4.0);
        check("sub_d127", bus16.data_out[127], 123.0);
        accept_result();

        // SIGMOID at 0
        for (int i = 0; i < 128; i++) a[i] = 0.0;
        do_op(4'd6, 0.0, lat);
        check("sigmoid_d64", bus16.data_out[64], 0.5);
        accept_result();

        // Illegal opcode 13 after a result that left data_out non-zero
        for (int i = 0; i < 128; i++) a[i] = 1.0 * i + 1.0;
        do_op(4'd5, 1.0, lat);
        check("delta_d9", bus16.data_out[9], 11.0);
        accept_result();
        do_op(4'd13, 0.0, lat);
        check("illegal_op_err", bus16.op_err, 1);
        check("illegal_data_nonzero", count_nonzero16(), 0);
        check("illegal_data_outK", bus16.data_outK, 0.0);
        accept_result();
        check("illegal_op_err_cleared", bus16.op_err, 0);

        // Back-to-back on all three lane configurations
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acc16.delete();
        acc128.delete();
        acc1.delete();
        for (int i = 0; i < 128; i++) begin
            a[i] = 1.0 * i;
            b[i] = 2.0 * i;
        end
        op        = 4'd1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 400; i++) tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_l16_spacing1", (acc16.size() >= 3) ? acc16[1] - acc16[0] : -1, 10);
        check("b2b_l16_spacing2", (acc16.size() >= 3) ? acc16[2] - acc16[1] : -1, 10);
        check("b2b_l128_spacing1", (acc128.size() >= 3) ? acc128[1] - acc128[0] : -1, 3);
        check("b2b_l128_spacing2", (acc128.size() >= 3) ? acc128[2] - acc128[1] : -1, 3);
        check("b2b_l1_spacing1", (acc1.size() >= 3) ? acc1[1] - acc1[0] : -1, 130);
        check("b2b_l1_spacing2", (acc1.size() >= 3) ? acc1[2] - acc1[1] : -1, 130);
        check("b2b_l128_d127", bus128.data_out[127], 381.0);
        check("b2b_l1_d127", bus1.data_out[127], 381.0);
        check("b2b_l1_d5", bus1.data_out[5], 15.0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
